// File: rtl/prom_pkg.sv
// Shared types and sizes for the boot RAM loader.
// The checksum build is selected with PROM_LOADER_CKSUM_EN.
package prom_pkg;

  localparam int PROM_ADR_W     = 9;
  localparam int PROM_DEPTH     = 512;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prom_byte_packer.sv
// Little-endian 8-to-32 assembler.
// word_valid flags the beat carrying the top byte.
module prom_byte_packer
  import prom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        fire,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word       = {in_data, sr};
  assign word_valid = fire & (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (fire) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    sr[7:0]   <= in_data;
        2'd1:    sr[15:8]  <= in_data;
        2'd2:    sr[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prom_loader.sv
// Boot image loader: byte stream to 32-bit boot RAM writes.
// PROM_LOADER_CKSUM_EN adds a trailing 32-bit checksum check.
module prom_loader
  import prom_pkg::*;
#(
  parameter int ADR_W = PROM_ADR_W,
  parameter int DEPTH = PROM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ADR_W-1:0] wr_adr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t state, state_nx;

  logic           fire;
  logic           pk_fire;
  logic           pk_valid;
  logic [31:0]    pk_word;
  logic           start_ok;
  logic           hb;
  logic [7:0]     nlo;
  logic [15:0]    n16;
  logic           hdr_ok;
  logic [ADR_W:0] n;
  logic [ADR_W:0] idx;
  logic           all_in;
  logic           last_wr;

  assign fire     = in_valid & in_ready;
  assign start_ok = start & (state == S_IDLE |
                             state == S_DONE |
                             state == S_ERR);
  assign pk_fire  = fire & (state == S_DATA | state == S_CK);
  assign n16      = {in_data, nlo};
  assign hdr_ok   = (n16 != 16'd0) & (n16 <= 16'(DEPTH));
  assign all_in   = (idx == n);
  // final word is on the write port this cycle
  assign last_wr  = wr_en & all_in;

  assign busy = (state == S_HDR) | (state == S_DATA) |
                (state == S_CK);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  prom_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .fire       (pk_fire),
    .in_data    (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

`ifdef PROM_LOADER_CKSUM_EN
  logic [31:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 32'd0;
    end else if (start_ok) begin
      acc <= 32'd0;
    end else if (wr_en) begin
      acc <= acc + wr_data;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx = S_HDR;
      end
      S_HDR: begin
        in_ready = 1'b1;
        if (fire && hb) state_nx = hdr_ok ? S_DATA : S_ERR;
      end
      S_DATA: begin
`ifdef PROM_LOADER_CKSUM_EN
        in_ready = 1'b1;
        if (last_wr) state_nx = S_CK;
`else
        in_ready = !all_in;
        if (last_wr) state_nx = S_DONE;
`endif
      end
`ifdef PROM_LOADER_CKSUM_EN
      S_CK: begin
        in_ready = 1'b1;
        if (pk_valid) state_nx = (pk_word == acc) ? S_DONE : S_ERR;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      hb      <= 1'b0;
      nlo     <= 8'd0;
      n       <= '0;
      idx     <= '0;
      wr_en   <= 1'b0;
      wr_adr  <= '0;
      wr_data <= 32'd0;
    end else begin
      state <= state_nx;
      wr_en <= 1'b0;
      if (start_ok) begin
        hb  <= 1'b0;
        idx <= '0;
      end
      if (state == S_HDR && fire) begin
        hb <= 1'b1;
        if (!hb) nlo <= in_data;
        else     n   <= n16[ADR_W:0];
      end
      if (state == S_DATA && pk_valid && !all_in) begin
        wr_en   <= 1'b1;
        wr_adr  <= idx[ADR_W-1:0];
        wr_data <= pk_word;
        idx     <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Self-checking bench for prom_loader with a write scoreboard.
// Define PROM_LOADER_CKSUM_EN to also exercise the checksum path.
module tb_prom_loader;
  import prom_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [8:0]  wr_adr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int total = 0;

  logic [40:0] exp_q[$];
  logic [31:0] mem [0:511];
  logic [31:0] img [0:511];

  prom_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // target RAM as the CPU will see it
  always @(posedge clk) if (wr_en) mem[wr_adr] <= wr_data;

  always @(negedge clk) begin
    logic [40:0] e;
    if (wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected adr=%0d data=%h", wr_adr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_adr, wr_data} !== e)
          $display("FAIL write got adr=%0d data=%h need adr=%0d data=%h",
                   wr_adr, wr_data, e[40:32], e[31:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int k;
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout in_ready=%b need 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input int i, input int gapmax);
    logic [31:0] w;
    w = img[i];
    exp_q.push_back({9'(i), w});
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gapmax);
  endtask

  task automatic send_image(input int nw, input int gapmax,
                            input logic [31:0] cdelta);
    logic [15:0] n;
    logic [31:0] c;
    n = 16'(nw);
    c = cdelta;
    send_byte(n[7:0], gapmax);
    send_byte(n[15:8], gapmax);
    for (int i = 0; i < nw; i++) begin
      c = c + img[i];
      send_word(i, gapmax);
    end
`ifdef PROM_LOADER_CKSUM_EN
    for (int b = 0; b < 4; b++) send_byte(c[8*b +: 8], gapmax);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done | err) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!(done | err)) begin
      total++;
      $display("FAIL end_timeout done=%b err=%b need one set", done, err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, wr_en, wr_adr, wr_data, busy, done, err} !== 46'd0)
      $display("FAIL reset_outputs got %h need 0",
               {in_ready, wr_en, wr_adr, wr_data, busy, done, err});
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, busy, done, err} !== 4'b0000)
      $display("FAIL idle_outputs got %b need 0000",
               {in_ready, busy, done, err});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    pulse_start();
    total++;
    if ({busy, in_ready} !== 2'b11)
      $display("FAIL basic_hdr busy/rdy=%b need 11", {busy, in_ready});
    else pass_cnt++;
    send_image(2, 0, 32'd0);
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err, busy} !== 3'b100)
      $display("FAIL basic_end done/err/busy=%b need 100", {done, err, busy});
    else pass_cnt++;
    total++;
    if (exp_q.size() != 0 || mem[0] !== 32'h12345678 ||
        mem[1] !== 32'hDEADBEEF)
      $display("FAIL basic_mem m0=%h m1=%h pend=%0d need 12345678 deadbeef 0",
               mem[0], mem[1], exp_q.size());
    else pass_cnt++;
    total++;
    if ({wr_en, wr_adr} !== {1'b0, 9'd1})
      $display("FAIL basic_hold en=%b adr=%0d need 0 1", wr_en, wr_adr);
    else pass_cnt++;
  endtask

  task automatic test_bad_header();
    pulse_start();
    total++;
    if (done !== 1'b0)
      $display("FAIL start_clr_done done=%b need 0", done);
    else pass_cnt++;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++;
    if ({err, done, busy, in_ready} !== 4'b1000)
      $display("FAIL n0 err/done/busy/rdy=%b need 1000",
               {err, done, busy, in_ready});
    else pass_cnt++;
    pulse_start();
    total++;
    if ({err, busy} !== 2'b01)
      $display("FAIL start_clr_err err/busy=%b need 01", {err, busy});
    else pass_cnt++;
    send_byte(8'h01, 0);
    total++;
    if (err !== 1'b0)
      $display("FAIL n513_early err=%b need 0", err);
    else pass_cnt++;
    send_byte(8'h02, 0);
    total++;
    if ({err, busy} !== 2'b10)
      $display("FAIL n513 err/busy=%b need 10", {err, busy});
    else pass_cnt++;
  endtask

  task automatic test_full();
    int bad;
    for (int i = 0; i < 512; i++) img[i] = $urandom;
    pulse_start();
    send_image(512, 2, 32'd0);
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL full_end done/err=%b pend=%0d need 10 0",
               {done, err}, exp_q.size());
    else pass_cnt++;
    total++;
    if (wr_adr !== 9'd511)
      $display("FAIL full_last_adr got %0d need 511", wr_adr);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== img[i]) bad++;
    total++;
    if (bad != 0)
      $display("FAIL full_readback bad_words=%0d need 0", bad);
    else pass_cnt++;
  endtask

`ifdef PROM_LOADER_CKSUM_EN
  task automatic test_cksum();
    img[0] = 32'd1;
    pulse_start();
    send_image(1, 0, 32'd0);
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10)
      $display("FAIL cksum_ok done/err=%b need 10", {done, err});
    else pass_cnt++;
    mem[0] = 32'd0;
    pulse_start();
    send_image(1, 0, 32'd1);
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b01)
      $display("FAIL cksum_bad done/err=%b need 01", {done, err});
    else pass_cnt++;
    total++;
    if (mem[0] !== 32'd1 || exp_q.size() != 0)
      $display("FAIL cksum_bad_mem m0=%h need 1", mem[0]);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    img[0] = 32'h11111111;
    img[1] = 32'h22222222;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(0, 0);
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, wr_adr, wr_data, busy, done, err} !== 46'd0)
      $display("FAIL midrst_outputs got %h need 0",
               {in_ready, wr_en, wr_adr, wr_data, busy, done, err});
    else pass_cnt++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    img[0] = 32'hA5A5A5A5;
    pulse_start();
    send_image(1, 0, 32'd0);
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10 || mem[0] !== 32'hA5A5A5A5 ||
        wr_adr !== 9'd0 || exp_q.size() != 0)
      $display("FAIL midrst_reload done/err=%b m0=%h adr=%0d need 10 a5a5a5a5 0",
               {done, err}, mem[0], wr_adr);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    img[0] = 32'h0BADF00D;
    img[1] = 32'hCAFEBABE;
    img[2] = 32'h76543210;
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(0, 1);
    exp_q.push_back({9'd1, img[1]});
    send_byte(img[1][7:0], 0);
    pulse_start();
    total++;
    if (busy !== 1'b1)
      $display("FAIL ign_busy busy=%b need 1", busy);
    else pass_cnt++;
    send_byte(img[1][15:8], 0);
    send_byte(img[1][23:16], 0);
    send_byte(img[1][31:24], 0);
    send_word(2, 1);
`ifdef PROM_LOADER_CKSUM_EN
    begin
      logic [31:0] c;
      c = img[0] + img[1] + img[2];
      for (int b = 0; b < 4; b++) send_byte(c[8*b +: 8], 0);
    end
`endif
    wait_end();
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL ign_end done/err=%b pend=%0d need 10 0",
               {done, err}, exp_q.size());
    else pass_cnt++;
    total++;
    if (mem[0] !== img[0] || mem[1] !== img[1] || mem[2] !== img[2])
      $display("FAIL ign_mem %h %h %h need %h %h %h",
               mem[0], mem[1], mem[2], img[0], img[1], img[2]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_full();
`ifdef PROM_LOADER_CKSUM_EN
    test_cksum();
`endif
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
